// File: rtl/pwm_vsi_nch.sv
// pwm_vsi_nch - multi-leg edge-aligned PWM modulator for a voltage-source inverter.
//
// One up-counter is shared by all legs. It runs 0..P-1, where P is the
// shadowed period. Each leg compares its shadowed duty word against the
// counter and drives a complementary pair of gate commands.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous, active-high reset
//   en      in   run enable (low = modulator stopped, shadows follow inputs)
//   period  in   CW     carrier period in clk cycles
//   d       in   N_CH*CW packed duty words, leg i at [i*CW +: CW]
//   dead    in   DTW    dead time in clk cycles
//   S_hi    out  N_CH   registered high-side gate commands
//   S_lo    out  N_CH   registered low-side gate commands
//   sync    out  1      registered pulse for the counter==0 cycle
//
// Build option
//   PWM_VSI_DEADTIME_EN  when defined, dead-time insertion is built in.
//                        When undefined, the dead port is ignored.
module pwm_vsi_nch #(
    parameter int N_CH = 3,
    parameter int CW   = 10,
    parameter int DTW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CW-1:0]        period,
    input  logic [N_CH*CW-1:0]   d,
    input  logic [DTW-1:0]       dead,
    output logic [N_CH-1:0]      S_hi,
    output logic [N_CH-1:0]      S_lo,
    output logic                 sync
);

    logic [CW-1:0]      r_cnt_p0;
    logic [CW-1:0]      r_per_sh;
    logic [N_CH*CW-1:0] r_d_sh;
    logic [N_CH-1:0]    r_s_hi_p1;
    logic [N_CH-1:0]    r_s_lo_p1;
    logic               r_sync_p1;

    logic               w_run;
    logic               w_act;
    logic               w_wrap;
    logic               w_load;
    logic [N_CH-1:0]    w_ref_p0;

    // A period below 2 stalls the modulator: counter parked, legs off.
    assign w_run  = (r_per_sh >= CW'(2));
    assign w_act  = en & w_run;
    assign w_wrap = (r_cnt_p0 == (r_per_sh - CW'(1)));
    // While stalled or stopped, the shadows keep tracking the inputs so a
    // usable period is picked up without needing an en toggle.
    assign w_load = ~w_act | w_wrap;

    // ---- stage p0: carrier counter, shadow registers, references ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_p0 <= '0;
        end else if (~w_act | w_wrap) begin
            r_cnt_p0 <= '0;
        end else begin
            r_cnt_p0 <= r_cnt_p0 + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_sh <= '0;
            r_d_sh   <= '0;
        end else if (w_load) begin
            r_per_sh <= period;
            r_d_sh   <= d;
        end
    end

    always_comb begin
        w_ref_p0 = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_ref_p0[i] = w_run & (r_d_sh[i*CW +: CW] > r_cnt_p0);
        end
    end

    // ---- stage p1: registered gate commands and sync ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p1 <= w_act & (r_cnt_p0 == '0);
        end
    end

`ifdef PWM_VSI_DEADTIME_EN
    // Run-length counter per leg: how many consecutive cycles the reference
    // has held its present value, saturating at 2**DTW so that it can always
    // exceed the largest dead time.
    localparam int              KW    = DTW + 1;
    localparam logic [KW-1:0]   K_SAT = KW'(1) << DTW;

    logic [DTW-1:0]  r_dead_sh;
    logic [N_CH-1:0] r_ref_prev_p1;
    logic [KW-1:0]   r_run_p1 [N_CH];
    logic [KW-1:0]   w_run_nxt [N_CH];
    logic [N_CH-1:0] w_on;

    function automatic logic [KW-1:0] f_sat_inc(input logic [KW-1:0] v);
        if (v == K_SAT) begin
            return v;
        end
        return v + KW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dead_sh <= '0;
        end else if (w_load) begin
            r_dead_sh <= dead;
        end
    end

    // An edge restarts the run at 1; a leg's output may assert only once the
    // run is longer than the dead time, so dead=0 gives no gap at all.
    always_comb begin
        w_on = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ref_p0[i] != r_ref_prev_p1[i]) begin
                w_run_nxt[i] = KW'(1);
            end else begin
                w_run_nxt[i] = f_sat_inc(r_run_p1[i]);
            end
            w_on[i] = (w_run_nxt[i] > {1'b0, r_dead_sh});
        end
    end

    // Clearing prev/run to zero makes the first active cycle look like a
    // fresh edge, so both outputs start low after enable or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_prev_p1 <= '0;
            r_s_hi_p1     <= '0;
            r_s_lo_p1     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_run_p1[i] <= '0;
            end
        end else if (~w_act) begin
            r_ref_prev_p1 <= '0;
            r_s_hi_p1     <= '0;
            r_s_lo_p1     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_run_p1[i] <= '0;
            end
        end else begin
            r_ref_prev_p1 <= w_ref_p0;
            r_s_hi_p1     <= w_ref_p0 & w_on;
            r_s_lo_p1     <= ~w_ref_p0 & w_on;
            for (int i = 0; i < N_CH; i++) begin
                r_run_p1[i] <= w_run_nxt[i];
            end
        end
    end
`else
    logic w_unused_dead;
    assign w_unused_dead = ^dead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_hi_p1 <= '0;
            r_s_lo_p1 <= '0;
        end else if (~w_act) begin
            r_s_hi_p1 <= '0;
            r_s_lo_p1 <= '0;
        end else begin
            r_s_hi_p1 <= w_ref_p0;
            r_s_lo_p1 <= ~w_ref_p0;
        end
    end
`endif

    assign S_hi = r_s_hi_p1;
    assign S_lo = r_s_lo_p1;
    assign sync = r_sync_p1;

endmodule

// File: tb/tb_pwm_vsi_nch.sv
// Testbench for pwm_vsi_nch: directed scenarios plus randomized stimulus
// checked every cycle against a behavioural model of the modulator.
module tb_pwm_vsi_nch;

    localparam int N_CH = 3;
    localparam int CW   = 10;
    localparam int DTW  = 4;

    logic                clk;
    logic                rst;
    logic                en;
    logic [CW-1:0]       period_in;
    logic [N_CH*CW-1:0]  d_in;
    logic [DTW-1:0]      dead_in;
    logic [N_CH-1:0]     S_hi;
    logic [N_CH-1:0]     S_lo;
    logic                sync;

    pwm_vsi_nch #(.N_CH(N_CH), .CW(CW), .DTW(DTW)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .period (period_in),
        .d      (d_in),
        .dead   (dead_in),
        .S_hi   (S_hi),
        .S_lo   (S_lo),
        .sync   (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state (value of counter during the present cycle,
    // shadowed settings, and the expected registered outputs).
    int              m_cnt;
    int              m_per;
    int              m_d [N_CH];
    logic [N_CH-1:0] e_hi;
    logic [N_CH-1:0] e_lo;
    logic            e_sync;
`ifdef PWM_VSI_DEADTIME_EN
    int              m_dead;
    int              m_cyc;
    int              m_start [N_CH];
    bit              m_prev [N_CH];
    bit              m_fresh [N_CH];
`endif

    int acc_hi [N_CH];
    int acc_lo [N_CH];
    int acc_sync;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_per  = 0;
        e_hi   = '0;
        e_lo   = '0;
        e_sync = 1'b0;
        for (int i = 0; i < N_CH; i++) m_d[i] = 0;
`ifdef PWM_VSI_DEADTIME_EN
        m_dead = 0;
        m_cyc  = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_fresh[i] = 1'b1;
            m_prev[i]  = 1'b0;
            m_start[i] = 0;
        end
`endif
    endtask

    // Applies the rules for one rising edge using the inputs now on the pins.
    task automatic model_edge();
        bit run;
        bit ld;
        bit r;
        bit on;
        int nxt;
        if (rst) begin
            model_reset();
        end else begin
            run = (m_per >= 2);
            ld  = !en || !run || (m_cnt == m_per - 1);
            if (!en || !run) begin
                e_hi   = '0;
                e_lo   = '0;
                e_sync = 1'b0;
                nxt    = 0;
`ifdef PWM_VSI_DEADTIME_EN
                for (int i = 0; i < N_CH; i++) m_fresh[i] = 1'b1;
`endif
            end else begin
                e_sync = (m_cnt == 0);
`ifdef PWM_VSI_DEADTIME_EN
                m_cyc++;
`endif
                for (int i = 0; i < N_CH; i++) begin
                    r  = (m_d[i] > m_cnt);
                    on = 1'b1;
`ifdef PWM_VSI_DEADTIME_EN
                    if (m_fresh[i] || (r != m_prev[i])) begin
                        m_start[i] = m_cyc;
                        m_prev[i]  = r;
                        m_fresh[i] = 1'b0;
                    end
                    on = ((m_cyc - m_start[i] + 1) > m_dead);
`endif
                    e_hi[i] = r & on;
                    e_lo[i] = !r & on;
                end
                nxt = (m_cnt + 1) % m_per;
            end
            m_cnt = nxt;
            if (ld) begin
                m_per = int'(period_in);
                for (int i = 0; i < N_CH; i++) m_d[i] = int'(d_in[i*CW +: CW]);
`ifdef PWM_VSI_DEADTIME_EN
                m_dead = int'(dead_in);
`endif
            end
        end
    endtask

    task automatic clr_acc();
        for (int i = 0; i < N_CH; i++) begin
            acc_hi[i] = 0;
            acc_lo[i] = 0;
        end
        acc_sync = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("s_hi", 32'(S_hi), 32'(e_hi));
        chk("s_lo", 32'(S_lo), 32'(e_lo));
        chk("sync", 32'(sync), 32'(e_sync));
        chk("overlap", 32'(S_hi & S_lo), 32'd0);
        for (int i = 0; i < N_CH; i++) begin
            acc_hi[i] += int'(S_hi[i]);
            acc_lo[i] += int'(S_lo[i]);
        end
        acc_sync += int'(sync);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Advance until the model counter for the present cycle equals v.
    task automatic wait_cnt(input int v, input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            if (m_cnt == v) found = 1'b1;
            else tick();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        period_in = '0;
        d_in      = '0;
        dead_in   = '0;
        model_reset();
        clr_acc();

        // Reset state
        ticks(3);
        chk("rst_hi", 32'(S_hi), 32'd0);
        chk("rst_lo", 32'(S_lo), 32'd0);
        chk("rst_sync", 32'(sync), 32'd0);

        // Duty 0 / 50 % / 100 % on three legs
        rst       = 1'b0;
        period_in = CW'(10);
        d_in[0*CW +: CW] = CW'(0);
        d_in[1*CW +: CW] = CW'(5);
        d_in[2*CW +: CW] = CW'(10);
        ticks(2);
        en = 1'b1;
        clr_acc();
        ticks(10);
        chk("d0_hi", 32'(acc_hi[0]), 32'd0);
        chk("d5_hi", 32'(acc_hi[1]), 32'd5);
        chk("d5_lo", 32'(acc_lo[1]), 32'd5);
        chk("d10_hi", 32'(acc_hi[2]), 32'd10);
        chk("sync_per", 32'(acc_sync), 32'd1);

        // Duty change mid-period takes effect at the next period
        d_in[1*CW +: CW] = CW'(3);
        ticks(12);
        wait_cnt(0, "wait_c0");
        clr_acc();
        ticks(4);
        d_in[1*CW +: CW] = CW'(7);
        ticks(6);
        chk("old_duty", 32'(acc_hi[1]), 32'd3);
        clr_acc();
        ticks(10);
        chk("new_duty", 32'(acc_hi[1]), 32'd7);

        // Asynchronous reset mid-period
        wait_cnt(6, "wait_c6");
        chk("pre_rst_hi", 32'(S_hi[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_hi", 32'(S_hi), 32'd0);
        chk("arst_lo", 32'(S_lo), 32'd0);
        chk("arst_sync", 32'(sync), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        ticks(25);

        // Degenerate periods stall the modulator
        period_in = CW'(1);
        ticks(12);
        clr_acc();
        ticks(5);
        chk("p1_hi", 32'(acc_hi[0] + acc_hi[1] + acc_hi[2]), 32'd0);
        chk("p1_lo", 32'(acc_lo[0] + acc_lo[1] + acc_lo[2]), 32'd0);
        chk("p1_sync", 32'(acc_sync), 32'd0);
        period_in = CW'(0);
        ticks(2);
        clr_acc();
        ticks(5);
        chk("p0_lo", 32'(acc_lo[0] + acc_lo[1] + acc_lo[2]), 32'd0);
        chk("p0_sync", 32'(acc_sync), 32'd0);
        en = 1'b0;
        period_in = CW'(10);
        ticks(2);
        en = 1'b1;
        tick();
        chk("en_sync", 32'(sync), 32'd1);
        ticks(10);

`ifdef PWM_VSI_DEADTIME_EN
        // Dead time on a 50 % leg
        period_in = CW'(20);
        dead_in   = DTW'(2);
        d_in[0*CW +: CW] = CW'(10);
        ticks(45);
        wait_cnt(0, "wait_dt1");
        clr_acc();
        ticks(20);
        chk("dt_hi", 32'(acc_hi[0]), 32'd8);
        chk("dt_lo", 32'(acc_lo[0]), 32'd8);

        // Pulse shorter than the dead time is swallowed
        dead_in = DTW'(3);
        d_in[0*CW +: CW] = CW'(2);
        ticks(45);
        wait_cnt(0, "wait_dt2");
        clr_acc();
        ticks(20);
        chk("short_hi", 32'(acc_hi[0]), 32'd0);
        chk("short_lo", 32'(acc_lo[0]), 32'd15);
`endif

        // Randomized operation
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) period_in = CW'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) begin
                int ch;
                ch = int'($urandom_range(0, N_CH - 1));
                d_in[ch*CW +: CW] = CW'($urandom_range(0, 45));
            end
            if ($urandom_range(0, 7) == 0) dead_in = DTW'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) en = ~en;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
